spi_receive_con: RTL

Main-FPGA receiver for the peripheral-to-main pixel link. It sits on the main FPGA and takes in the CS, DCLK and parallel data lines driven by the peripheral FPGA's SPI sender. It synchronizes these asynchronous inputs into `clk_in`, samples data on each DCLK rising edge while CS is low, and reassembles MSB-first beats into `DATA_WIDTH`-bit words. Each completed word is presented with a one-cycle valid pulse.

---
 rtl/spi_receive_con_if.sv | 21 ++
 rtl/spi_receive_con.sv | 90 +++++++++
 2 files changed

// File: rtl/spi_receive_con_if.sv
// spi_receive_con_if: pixel-link pins from the peripheral sender plus the reassembled word outputs.
interface spi_receive_con_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LINES      = 4
);
  logic [LINES-1:0]      chip_data_in;
  logic                  chip_clk_in;
  logic                  chip_sel_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid_out;
  logic                  frame_err_out;
  logic                  busy_out;
  modport master (
    output chip_data_in, chip_clk_in, chip_sel_in,
    input  data_out, data_valid_out, frame_err_out, busy_out
  );
  modport slave (
    input  chip_data_in, chip_clk_in, chip_sel_in,
    output data_out, data_valid_out, frame_err_out, busy_out
  );
endinterface

// File: rtl/spi_receive_con.sv
// spi_receive_con: synchronizes CS/DCLK/data and reassembles MSB-first beats into words.
module spi_receive_con #(
  parameter int DATA_WIDTH  = 8,
  parameter int LINES       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int BEATS       = DATA_WIDTH / LINES,
  parameter int BEAT_SIZE   = $clog2(BEATS + 1)
) (
  input logic clk_in,
  input logic rst_n_in,
  spi_receive_con_if.slave bus
);
  typedef enum logic {IDLE, ACTIVE} state_e;
  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, cs_sync_q, fill_q;
  logic [SYNC_STAGES-1:0][LINES-1:0] data_sync_q;
  logic clk_prev_q, cs_prev_q, armed_q;
  logic [BEAT_SIZE-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_nx, word_q, word_d;
  logic valid_q, valid_d, err_q, err_d;
  logic dclk_s, cs_s, dclk_rise, cs_fall, cs_rise;
  logic [LINES-1:0] data_s;
  assign dclk_s    = clk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign data_s    = data_sync_q[SYNC_STAGES-1];
  assign dclk_rise = dclk_s & ~clk_prev_q;
  // A frame already in progress at reset release must not look like a fresh CS fall.
  assign cs_fall   = ~cs_s & cs_prev_q & armed_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign shift_nx  = (shift_q << LINES) | DATA_WIDTH'(data_s);
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      clk_sync_q  <= '0;
      cs_sync_q   <= '1;
      data_sync_q <= '0;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      clk_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.chip_clk_in};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.chip_sel_in};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.chip_data_in};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
      clk_prev_q  <= dclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (state_q == IDLE) begin
      if (cs_fall) begin
        state_d = ACTIVE;
        cnt_d   = '0;
        shift_d = '0;
      end
    end else if (cs_rise) begin
      state_d = IDLE;
      err_d   = cnt_q != '0;
      cnt_d   = '0;
    end else if (dclk_rise && !cs_s) begin
      shift_d = shift_nx;
      valid_d = cnt_q == BEAT_SIZE'(BEATS - 1);
      word_d  = valid_d ? shift_nx : word_q;
      cnt_d   = valid_d ? '0 : cnt_q + 1'b1;
    end
  end
  assign bus.data_out       = word_q;
  assign bus.data_valid_out = valid_q;
  assign bus.frame_err_out  = err_q;
  assign bus.busy_out       = state_q == ACTIVE;
endmodule
